// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding / load-use hazard unit.
// The master is the pipeline datapath; the slave is fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int NSTG  = 2,
  parameter int CNT_W = 16
);
  localparam int SW = $clog2(NSTG + 1);

  logic                 flush_i;
  logic [NSRC*AW-1:0]   ex_rs_i;
  logic [NSTG*AW-1:0]   stg_rd_i;
  logic [NSTG-1:0]      stg_regwrite_i;
  logic                 id_valid_i;
  logic [NSRC*AW-1:0]   id_rs_i;
  logic [AW-1:0]        ex_rd_i;
  logic                 ex_regwrite_i;
  logic                 ex_memread_i;
  logic [NSRC*SW-1:0]   fwd_sel_o;
  logic                 stall_o;
  logic [CNT_W-1:0]     stall_cnt_o;
  logic [CNT_W-1:0]     fwd_cnt_o;

  modport master (
    output flush_i, ex_rs_i, stg_rd_i, stg_regwrite_i, id_valid_i, id_rs_i,
           ex_rd_i, ex_regwrite_i, ex_memread_i,
    input  fwd_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );

  modport slave (
    input  flush_i, ex_rs_i, stg_rd_i, stg_regwrite_i, id_valid_i, id_rs_i,
           ex_rd_i, ex_regwrite_i, ex_memread_i,
    output fwd_sel_o, stall_o, stall_cnt_o, fwd_cnt_o
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation with saturating
// stall/forward statistics counters.
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_unit_if.slave   bus
);
  localparam int SW = $clog2(NSTG + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         scnt_q, scnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;
  logic [NSRC*SW-1:0] fwd_sel_s;
  logic [NSRC*SW-1:0] fwd_sel_out_s;
  logic               hazard_s;
  logic               stall_s;

  // Descending scan so the nearest matching stage overwrites farther ones.
  always_comb begin
    fwd_sel_s = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (bus.stg_regwrite_i[k] && (bus.stg_rd_i[k*AW +: AW] != '0) &&
            (bus.stg_rd_i[k*AW +: AW] == bus.ex_rs_i[s*AW +: AW])) begin
          fwd_sel_s[s*SW +: SW] = SW'(k + 1);
        end else begin
          fwd_sel_s[s*SW +: SW] = fwd_sel_s[s*SW +: SW];
        end
      end
    end
  end

  always_comb begin
    hazard_s = 1'b0;
    if (bus.id_valid_i && bus.ex_memread_i && bus.ex_regwrite_i && (bus.ex_rd_i != '0)) begin
      for (int s = 0; s < NSRC; s++) begin
        if (bus.id_rs_i[s*AW +: AW] == bus.ex_rd_i) begin
          hazard_s = 1'b1;
        end else begin
          hazard_s = hazard_s;
        end
      end
    end else begin
      hazard_s = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      scnt_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard_s && (LOAD_LAT > 1)) begin
            state_d = STALL;
            scnt_d  = 3'(LOAD_LAT - 1);
          end else begin
            state_d = IDLE;
            scnt_d  = 3'd0;
          end
        end
        STALL: begin
          scnt_d = scnt_q - 3'd1;
          if (scnt_q <= 3'd1) begin
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          state_d = IDLE;
          scnt_d  = 3'd0;
        end
      endcase
    end
  end

  // Reset and flush both mask the stall; reset also masks forwarding.
  always_comb begin
    stall_s       = 1'b0;
    fwd_sel_out_s = '0;
    if (!rst_i) begin
      stall_s       = 1'b0;
      fwd_sel_out_s = '0;
    end else begin
      fwd_sel_out_s = fwd_sel_s;
      if (bus.flush_i) begin
        stall_s = 1'b0;
      end else begin
        case (state_q)
          IDLE:    stall_s = hazard_s;
          STALL:   stall_s = 1'b1;
          default: stall_s = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!stall_s && (fwd_sel_out_s != '0) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      scnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.fwd_sel_o   = fwd_sel_out_s;
  assign bus.stall_o     = stall_s;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.fwd_cnt_o   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (NSRC=2, NSTG=2, LOAD_LAT=2, CNT_W=4).
module tb_fwd_hazard_unit;
  localparam int AW       = 5;
  localparam int NSRC     = 2;
  localparam int NSTG     = 2;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 4;
  localparam int SW       = 2;
  localparam int CNT_MAX  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.AW(AW), .NSRC(NSRC), .NSTG(NSTG), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(
    .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic             stall;
    logic [NSRC*SW-1:0] sel;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rs0, rs1, rd0, rd1;
    logic [1:0]    rw;
    logic [1:0]    sel0, sel1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall_cnt = 0;
  int   exp_fwd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_fwd(input logic [AW-1:0] rs0, rs1, rd0, rd1, input logic [1:0] rw);
    bus.ex_rs_i        = {rs1, rs0};
    bus.stg_rd_i       = {rd1, rd0};
    bus.stg_regwrite_i = rw;
  endtask

  task automatic set_load(input logic on);
    bus.id_valid_i    = on;
    bus.ex_memread_i  = on;
    bus.ex_regwrite_i = on;
    bus.ex_rd_i       = 5'd7;
    bus.id_rs_i       = {5'd7, 5'd3};
  endtask

  // One cycle: queue expectation, compare combinational outputs mid-cycle,
  // then advance the counter model and compare counters after the edge.
  task automatic step(input logic es, input logic [1:0] s0, input logic [1:0] s1);
    exp_t e;
    e.stall = es;
    e.sel   = {s1, s0};
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check("stall_o", {31'd0, bus.stall_o}, {31'd0, e.stall});
    check("fwd_sel_o", {28'd0, bus.fwd_sel_o}, {28'd0, e.sel});
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_stall_cnt = 0;
      exp_fwd_cnt   = 0;
    end else if (e.stall) begin
      if (exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
    end else if (e.sel != '0) begin
      if (exp_fwd_cnt < CNT_MAX) exp_fwd_cnt++;
    end
    check("stall_cnt_o", {28'd0, bus.stall_cnt_o}, exp_stall_cnt);
    check("fwd_cnt_o", {28'd0, bus.fwd_cnt_o}, exp_fwd_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{rs0:5'd5,  rs1:5'd6, rd0:5'd5,  rd1:5'd5, rw:2'b11, sel0:2'd1, sel1:2'd0};
    vecs[1] = '{rs0:5'd5,  rs1:5'd6, rd0:5'd5,  rd1:5'd5, rw:2'b10, sel0:2'd2, sel1:2'd0};
    vecs[2] = '{rs0:5'd0,  rs1:5'd0, rd0:5'd0,  rd1:5'd0, rw:2'b11, sel0:2'd0, sel1:2'd0};
    vecs[3] = '{rs0:5'd3,  rs1:5'd4, rd0:5'd4,  rd1:5'd3, rw:2'b11, sel0:2'd2, sel1:2'd1};
    vecs[4] = '{rs0:5'd7,  rs1:5'd7, rd0:5'd9,  rd1:5'd7, rw:2'b11, sel0:2'd2, sel1:2'd2};
    vecs[5] = '{rs0:5'd7,  rs1:5'd7, rd0:5'd7,  rd1:5'd7, rw:2'b00, sel0:2'd0, sel1:2'd0};
    vecs[6] = '{rs0:5'd31, rs1:5'd1, rd0:5'd31, rd1:5'd1, rw:2'b11, sel0:2'd1, sel1:2'd2};
    vecs[7] = '{rs0:5'd8,  rs1:5'd8, rd0:5'd8,  rd1:5'd8, rw:2'b01, sel0:2'd1, sel1:2'd1};

    bus.flush_i = 1'b0;
    rst_n       = 1'b0;
    set_fwd(5'd5, 5'd6, 5'd5, 5'd5, 2'b11);
    set_load(1'b1);
    #1;
    // Reset masks both forwarding and stall even with live hazards.
    step(1'b0, 2'd0, 2'd0);
    step(1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
    set_load(1'b0);

    for (int i = 0; i < 8; i++) begin
      set_fwd(vecs[i].rs0, vecs[i].rs1, vecs[i].rd0, vecs[i].rd1, vecs[i].rw);
      step(1'b0, vecs[i].sel0, vecs[i].sel1);
    end
    check("fwd_cnt_after_table", {28'd0, bus.fwd_cnt_o}, 32'd6);

    do_reset();
    set_fwd(5'd0, 5'd0, 5'd0, 5'd0, 2'b00);

    // Load-use: exactly LOAD_LAT stall cycles.
    set_load(1'b1);
    step(1'b1, 2'd0, 2'd0);
    step(1'b1, 2'd0, 2'd0);
    set_load(1'b0);
    step(1'b0, 2'd0, 2'd0);
    check("stall_cnt_single_load", {28'd0, bus.stall_cnt_o}, 32'd2);

    // Held hazard: fresh stall in first IDLE cycle; no fwd counting while stalled.
    set_load(1'b1);
    set_fwd(5'd5, 5'd6, 5'd5, 5'd5, 2'b11);
    step(1'b1, 2'd1, 2'd0);
    step(1'b1, 2'd1, 2'd0);
    step(1'b1, 2'd1, 2'd0);
    step(1'b1, 2'd1, 2'd0);
    set_load(1'b0);
    step(1'b0, 2'd1, 2'd0);

    do_reset();
    set_fwd(5'd0, 5'd0, 5'd0, 5'd0, 2'b00);

    // Flush in the second stall cycle.
    set_load(1'b1);
    step(1'b1, 2'd0, 2'd0);
    bus.flush_i = 1'b1;
    step(1'b0, 2'd0, 2'd0);
    bus.flush_i = 1'b0;
    set_load(1'b0);
    step(1'b0, 2'd0, 2'd0);
    check("stall_cnt_flush", {28'd0, bus.stall_cnt_o}, 32'd1);

    // Flush in IDLE with a hazard, then the hazard stalls normally.
    set_load(1'b1);
    bus.flush_i = 1'b1;
    step(1'b0, 2'd0, 2'd0);
    bus.flush_i = 1'b0;
    step(1'b1, 2'd0, 2'd0);
    step(1'b1, 2'd0, 2'd0);
    set_load(1'b0);
    step(1'b0, 2'd0, 2'd0);

    // Reset during STALL aborts it; first post-reset cycle is IDLE.
    set_load(1'b1);
    step(1'b1, 2'd0, 2'd0);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 2'd0);
    step(1'b1, 2'd0, 2'd0);
    set_load(1'b0);
    step(1'b0, 2'd0, 2'd0);

    // Saturation of both counters.
    do_reset();
    set_fwd(5'd5, 5'd6, 5'd5, 5'd5, 2'b11);
    for (int i = 0; i < 20; i++) step(1'b0, 2'd1, 2'd0);
    check("fwd_cnt_saturated", {28'd0, bus.fwd_cnt_o}, 32'd15);
    set_load(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 2'd1, 2'd0);
    check("stall_cnt_saturated", {28'd0, bus.stall_cnt_o}, 32'd15);
    check("fwd_cnt_held", {28'd0, bus.fwd_cnt_o}, 32'd15);
    set_load(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
